fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage LEGv8 CPU.
- Owns the PC and drives the instruction-memory address.
- Captures fetched instructions into IF/ID for the decode stage (forwarding_control_path and register file).
- Applies branch redirects resolved in ID (BrTaken/UnCondBr) using a one-instruction branch delay slot, and holds on load-use stalls.

Parameters:
- ADDR_W, 64, PC and instruction-address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, encoding placed in IF/ID when it holds no valid instruction. Decodes to the decoder's default case: no register or memory writes, no branch.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use hazard from hazard unit; freezes PC and IF/ID.
- br_taken  in  1  BrTaken from decode for the instruction currently in IF/ID.
- uncond_br  in  1  UnCondBr from decode: 1 selects imm26 (B), 0 selects imm19 (B.LT/CBZ).
- imem_addr  out  ADDR_W  instruction-memory read address (= PC, combinational).
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- if_id_instr  out  32  instruction presented to decode.
- if_id_pc  out  ADDR_W  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- All state updates on posedge clk. reset dominates every other input, including mid-stall and mid-branch.
- Reset values:
  - PC = RESET_PC
  - if_id_instr = NOP_INSTR
  - if_id_pc = RESET_PC
  - if_id_valid = 0
  - fetch_count = 0
- Two-state FSM:
  - FILL: entered on reset; lasts exactly one cycle. Fetches RESET_PC into IF/ID, then goes to RUN unconditionally. stall and br_taken are ignored in FILL.
  - RUN: steady state.
- Branch target, combinational, in sub-module:
  - uncond_br=1: target = if_id_pc + (SE64(if_id_instr[25:0]) << 2)
  - uncond_br=0: target = if_id_pc + (SE64(if_id_instr[23:5]) << 2)
  - Two's-complement add, wraps modulo 2^ADDR_W, no overflow flag.
- RUN, stall=1:
  - PC, IF/ID and fetch_count all hold.
  - br_taken is ignored this cycle; decode re-evaluates the held instruction next cycle.
- RUN, stall=0, br_taken=1 and if_id_valid=1:
  - IF/ID <= {imem_rdata, PC, valid=1}. This is the delay-slot instruction and is never squashed.
  - PC <= target; fetch_count increments.
- RUN, stall=0, otherwise:
  - IF/ID <= {imem_rdata, PC, valid=1}.
  - PC <= PC + 4; fetch_count increments.
- br_taken while if_id_valid=0 is ignored; a bubble never redirects.
- Branch to self (offset 0): PC <= if_id_pc, which is legal and loops.
- Branch latency: target instruction appears in IF/ID two cycles after the branch occupied IF/ID. This assumes no stalls; each stall cycle adds one.
- PC increments and wraps modulo 2^ADDR_W; no alignment checking.
- fetch_count saturates at 32'hFFFFFFFF.
- if_id_instr is driven to NOP_INSTR whenever if_id_valid=0, so decode never sees stale data.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR
  - imm26/imm19 field bit positions
  - fetch FSM enum (FILL, RUN)
  - ADDR_W default
- One sub-module, branch_target_adder: sign-extends the selected immediate, shifts left 2, adds to PC. Combinational, reused later by the ID-stage comparator path.

Test Plan:
- Reset release: hold reset 2 cycles, then release.
  - During reset: imem_addr=0, if_id_valid=0, if_id_instr=32'h0.
  - Cycle after release: if_id_pc=0, valid=1, imem_addr=4.
  - fetch_count then 1, 2, 3 on successive cycles.
- Sequential fetch: 4 cycles with no stall/branch -> if_id_pc sequence 0, 4, 8, 12; if_id_instr matches the memory model at each address.
- Unconditional B:
  - Setup: place 32'h14000003 (B +3) at PC 8; assert br_taken=1, uncond_br=1 while it is in IF/ID.
  - Expected: next IF/ID holds PC 12 (delay slot), following holds PC 20.
  - Backward variant: imm26 = -2 at PC 16 -> target 8.
- Conditional CBZ:
  - Setup: CBZ with imm19 = 5 at PC 4; br_taken=1, uncond_br=0.
  - Expected: IF/ID sequence 4, 8, 24.
  - Same case with br_taken=0 -> 4, 8, 12.
- Stall with simultaneous branch:
  - Setup: stall=1 for 2 cycles while a B is in IF/ID, with br_taken=1 throughout.
  - During stall: IF/ID, PC and fetch_count frozen; no redirect.
  - On stall release: delay slot enters IF/ID and PC takes the target.
- Reset mid-operation: assert reset during a stall with br_taken=1 -> next cycle PC=0, if_id_valid=0, fetch_count=0, FSM in FILL.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 CPU constants, instruction field positions and fetch FSM states
package cpu_pkg;

   localparam int ADDR_W_DEFAULT = 64;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Branch immediates: imm26 for B, imm19 for B.cond / CBZ / CBNZ
   localparam int IMM26_MSB = 25;
   localparam int IMM26_LSB = 0;
   localparam int IMM19_MSB = 23;
   localparam int IMM19_LSB = 5;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory port and IF/ID register outputs of the fetch stage
interface fetch_stage_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT
);

   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       if_id_instr;
   logic [ADDR_W-1:0] if_id_pc;
   logic              if_id_valid;

   modport master (
      output imem_addr,
      output if_id_instr,
      output if_id_pc,
      output if_id_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      input  if_id_instr,
      input  if_id_pc,
      input  if_id_valid,
      output imem_rdata
   );

endinterface

// File: rtl/branch_target_adder.sv
// rtl/branch_target_adder.sv - PC-relative branch target: pc + (sign-extended imm26/imm19 << 2)
module branch_target_adder #(
   parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       instr,
   input  logic              uncond_br,
   output logic [ADDR_W-1:0] target
);
   import cpu_pkg::*;

   localparam int IMM26_W = IMM26_MSB - IMM26_LSB + 1;
   localparam int IMM19_W = IMM19_MSB - IMM19_LSB + 1;

   logic [ADDR_W-1:0] off26;
   logic [ADDR_W-1:0] off19;
   logic [ADDR_W-1:0] offset;
   logic              unused_opcode;

   assign off26 = {{(ADDR_W-IMM26_W-2){instr[IMM26_MSB]}}, instr[IMM26_MSB:IMM26_LSB], 2'b00};
   assign off19 = {{(ADDR_W-IMM19_W-2){instr[IMM19_MSB]}}, instr[IMM19_MSB:IMM19_LSB], 2'b00};

   assign offset = uncond_br ? off26 : off19;
   assign target = pc + offset;

   assign unused_opcode = ^instr[31:IMM26_MSB+1];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch with PC, IF/ID register, delay-slot branches and stall hold
module fetch_stage #(
   parameter int                ADDR_W    = cpu_pkg::ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
   parameter logic [31:0]       NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          br_taken,
   input  logic          uncond_br,
   fetch_stage_if.master bus,
   output logic [31:0]   fetch_count
);
   import cpu_pkg::*;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic              valid_q, valid_d;
   logic [31:0]       count_q, count_d;
   logic [ADDR_W-1:0] target;
   logic              capture;

   branch_target_adder #(
      .ADDR_W (ADDR_W)
   ) u_target (
      .pc        (if_pc_q),
      .instr     (ir_q),
      .uncond_br (uncond_br),
      .target    (target)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSTR;
         if_pc_q <= RESET_PC;
         valid_q <= 1'b0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         if_pc_q <= if_pc_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      if_pc_d = if_pc_q;
      valid_d = valid_q;
      count_d = count_q;
      capture = 1'b0;

      case (state_q)
         FILL: begin
            capture = 1'b1;
            state_d = RUN;
            pc_d    = pc_q + ADDR_W'(4);
         end
         RUN: begin
            // A bubble in IF/ID never redirects, and the delay slot is always kept.
            if (!stall) begin
               capture = 1'b1;
               pc_d    = (br_taken && valid_q) ? target : pc_q + ADDR_W'(4);
            end
         end
         default: state_d = FILL;
      endcase

      if (capture) begin
         ir_d    = bus.imem_rdata;
         if_pc_d = pc_q;
         valid_d = 1'b1;
         count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.if_id_instr = valid_q ? ir_q : NOP_INSTR;
   assign bus.if_id_pc    = if_pc_q;
   assign bus.if_id_valid = valid_q;
   assign fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed self-checking bench for fetch_stage
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic        uncond_br = 1'b0;
   logic [31:0] fetch_count;

   fetch_stage_if #(.ADDR_W(64)) bus ();

   fetch_stage #(
      .ADDR_W    (64),
      .RESET_PC  (64'h0),
      .NOP_INSTR (32'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .uncond_br   (uncond_br),
      .bus         (bus.master),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:63];
   always_comb bus.imem_rdata = mem[bus.imem_addr[7:2]];

   // Reference state: what the fetch stage must be showing after the last edge
   logic [63:0] m_pc, m_if_pc;
   logic [31:0] m_instr, m_count;
   bit          m_valid, m_fill, m_known;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_target(input logic [63:0] pc, input logic [31:0] instr,
                                                input bit uncond);
      logic [25:0] f26;
      logic [18:0] f19;
      longint      off;
      f26 = instr[25:0];
      f19 = instr[23:5];
      if (uncond) off = longint'($signed(f26)) * 4;
      else        off = longint'($signed(f19)) * 4;
      return pc + 64'(off);
   endfunction

   always @(negedge clk) begin
      if (m_known) begin
         chk("imem_addr", bus.imem_addr, m_pc);
         chk("if_id_pc", bus.if_id_pc, m_if_pc);
         chk("if_id_instr", 64'(bus.if_id_instr), 64'(m_instr));
         chk("if_id_valid", 64'(bus.if_id_valid), 64'(m_valid));
         chk("fetch_count", 64'(fetch_count), 64'(m_count));
      end
   end

   task automatic step(input bit r, input bit s, input bit b, input bit u);
      logic [63:0] n_pc, n_if_pc;
      logic [31:0] n_instr, n_count;
      bit          n_valid, n_fill, take;
      @(negedge clk);
      reset = r; stall = s; br_taken = b; uncond_br = u;
      n_pc = m_pc; n_if_pc = m_if_pc; n_instr = m_instr;
      n_count = m_count; n_valid = m_valid; n_fill = m_fill;
      if (r) begin
         n_pc = 64'h0; n_if_pc = 64'h0; n_instr = 32'h0;
         n_count = 0; n_valid = 0; n_fill = 1;
      end else if (m_fill || !s) begin
         take = !m_fill && b && m_valid;
         n_instr = mem[m_pc[7:2]];
         n_if_pc = m_pc;
         n_valid = 1;
         n_count = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 1;
         n_pc = take ? model_target(m_if_pc, m_instr, u) : m_pc + 64'd4;
         n_fill = 0;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_if_pc = n_if_pc; m_instr = n_instr;
      m_count = n_count; m_valid = n_valid; m_fill = n_fill;
      if (r) m_known = 1;
   endtask

   task automatic restart();
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
   endtask

   initial begin
      m_known = 0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;

      // Reset: two cycles, the second with a branch request that must be ignored
      step(1, 0, 0, 0);
      chk("rst_imem_addr", bus.imem_addr, 64'h0);
      chk("rst_valid", 64'(bus.if_id_valid), 64'h0);
      chk("rst_instr", 64'(bus.if_id_instr), 64'h0);
      step(1, 1, 1, 1);
      step(0, 0, 1, 1);
      chk("fill_if_pc", bus.if_id_pc, 64'h0);
      chk("fill_valid", 64'(bus.if_id_valid), 64'h1);
      chk("fill_imem_addr", bus.imem_addr, 64'h4);
      chk("fill_count", 64'(fetch_count), 64'd1);
      step(0, 0, 0, 0);
      chk("seq_if_pc_4", bus.if_id_pc, 64'h4);
      chk("seq_count_2", 64'(fetch_count), 64'd2);
      step(0, 0, 0, 0);
      chk("seq_if_pc_8", bus.if_id_pc, 64'h8);
      chk("seq_count_3", 64'(fetch_count), 64'd3);
      step(0, 0, 0, 0);
      chk("seq_if_pc_12", bus.if_id_pc, 64'hC);

      // B +3 at PC 8
      mem[2] = 32'h1400_0003;
      restart();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      chk("b_delay_slot", bus.if_id_pc, 64'd12);
      chk("b_target_pc", bus.imem_addr, 64'd20);
      step(0, 0, 0, 0);
      chk("b_target_ifid", bus.if_id_pc, 64'd20);

      // B -2 at PC 16
      mem[4] = 32'h17FF_FFFE;
      restart();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      chk("bback_delay_slot", bus.if_id_pc, 64'd20);
      step(0, 0, 0, 0);
      chk("bback_target", bus.if_id_pc, 64'd8);

      // CBZ imm19=5 at PC 4, taken then not taken
      mem[1] = 32'hB400_00A0;
      restart();
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("cbz_delay_slot", bus.if_id_pc, 64'd8);
      step(0, 0, 0, 0);
      chk("cbz_target", bus.if_id_pc, 64'd24);
      restart();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("cbz_not_taken", bus.if_id_pc, 64'd12);

      // Stall with B in IF/ID and br_taken held high
      restart();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 1);
         chk("stall_if_pc", bus.if_id_pc, 64'd8);
         chk("stall_pc", bus.imem_addr, 64'd12);
         chk("stall_count", 64'(fetch_count), 64'd3);
      end
      step(0, 0, 1, 1);
      chk("unstall_delay_slot", bus.if_id_pc, 64'd12);
      chk("unstall_target_pc", bus.imem_addr, 64'd20);
      chk("unstall_count", 64'(fetch_count), 64'd4);

      // Reset during a stall with a branch pending
      step(0, 1, 1, 1);
      step(1, 1, 1, 1);
      chk("midrst_pc", bus.imem_addr, 64'h0);
      chk("midrst_valid", 64'(bus.if_id_valid), 64'h0);
      chk("midrst_count", 64'(fetch_count), 64'h0);
      step(0, 1, 1, 1);
      chk("midrst_fill_if_pc", bus.if_id_pc, 64'h0);
      chk("midrst_fill_pc", bus.imem_addr, 64'h4);

      // Branch to self at PC 12
      mem[3] = 32'h1400_0000;
      restart();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      chk("self_delay_slot", bus.if_id_pc, 64'd16);
      chk("self_pc", bus.imem_addr, 64'd12);
      step(0, 0, 0, 0);
      chk("self_loop", bus.if_id_pc, 64'd12);

      // Random traffic, with memory biased toward short branches
      for (int i = 0; i < 64; i++) begin
         logic [31:0] w;
         w = $urandom;
         case ($urandom_range(0, 2))
            0: w = {6'b000101, 20'(($urandom_range(0, 1) != 0) ? 20'hFFFFF : 20'h0), 6'(w)};
            1: w = {8'hB4, 5'(($urandom_range(0, 1) != 0) ? 5'h1F : 5'h0), 14'(w >> 5), 5'(w)};
            default: ;
         endcase
         mem[i] = w;
      end
      restart();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0);
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
